// File: rtl/serdes_pkg.sv
// Shared definitions for the serial link: frame geometry helpers and receiver state type.
package serdes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } rx_state_t;

  // Smallest P with 2^P >= data_width + P + 1.
  function automatic int unsigned ecc_parity_bits(input int unsigned data_width);
    int unsigned p;
    p = 0;
    for (int unsigned i = 1; i < 32; i++) begin
      if (p == 0 && (32'd1 << i) >= data_width + i + 32'd1) p = i;
    end
    return p;
  endfunction

  function automatic int unsigned frame_len(input int unsigned data_width, input bit has_ecc);
    return has_ecc ? ecc_parity_bits(data_width) + data_width + 32'd1 : data_width;
  endfunction

endpackage

// File: rtl/secded_decoder.sv
// Combinational SECDED decode: i_code[k] is Hamming position k+1, the MSB is the overall parity bit.
module secded_decoder
  import serdes_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  localparam int unsigned P          = ecc_parity_bits(DATA_WIDTH),
  localparam int unsigned N          = P + DATA_WIDTH + 1
) (
  input  logic [N-1:0]          i_code,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_corrected,
  output logic                  o_uncorrectable
);

  // Codeword bits whose position has syndrome bit j set.
  function automatic logic [N-1:0] syn_mask(input int unsigned j);
    logic [N-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < N - 1; k++) m[k] = (((k + 1) >> j) & 32'd1) != 0;
    return m;
  endfunction

  // Codeword index carrying data bit d (non-power-of-2 positions, ascending).
  function automatic int unsigned data_pos(input int unsigned d);
    int unsigned cnt;
    int unsigned r;
    cnt = 0;
    r   = 0;
    for (int unsigned p = 1; p < N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == d) r = p - 1;
        cnt = cnt + 1;
      end
    end
    return r;
  endfunction

  logic [P-1:0] w_syn;
  logic         w_par_bad;

  for (genvar j = 0; j < P; j++) begin : g_syn
    assign w_syn[j] = ^(i_code & syn_mask(j));
  end

  assign w_par_bad = ^i_code;

  // A flip is applied only when overall parity says a single error occurred.
  for (genvar d = 0; d < DATA_WIDTH; d++) begin : g_data
    assign o_data[d] = i_code[data_pos(d)] ^ (w_par_bad && (w_syn == P'(data_pos(d) + 1)));
  end

  assign o_corrected     = w_par_bad;
  assign o_uncorrectable = ~w_par_bad & (|w_syn);

endmodule

// File: rtl/ecc_deserializer.sv
// Serial-link receiver with optional SECDED check and a 2-entry valid/ready output buffer.
module ecc_deserializer
  import serdes_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          HAS_ECC    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  serial_in,
  input  logic                  enable,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] parallel_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  err_corrected,
  output logic                  err_uncorrectable,
  output logic                  overrun,
  output logic                  frame_abort
);

  localparam int unsigned N  = frame_len(DATA_WIDTH, HAS_ECC);
  localparam int unsigned CW = $clog2(N + 1);

  rx_state_t             r_state, w_state_nxt;
  logic [N-1:0]          r_frame;
  logic [CW-1:0]         r_cnt;
  logic                  w_cap, w_first, w_abort, w_push, w_pop;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_cor, w_unc;
  logic [DATA_WIDTH-1:0] r_data0, r_data1;
  logic                  r_cor0, r_cor1, r_unc0, r_unc1;
  logic                  r_v0, r_v1, r_overrun, r_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_first     = 1'b0;
    w_abort     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && start) begin
          w_state_nxt = RECV;
          w_cap       = 1'b1;
          w_first     = 1'b1;
        end
      end
      RECV: begin
        if (enable) begin
          w_cap = 1'b1;
          if (start) begin
            w_first = 1'b1;
            w_abort = 1'b1;
          end else if (r_cnt == CW'(N - 1)) begin
            w_state_nxt = CHECK;
          end
        end
      end
      CHECK: begin
        w_push = 1'b1;
        if (enable && start) begin
          w_state_nxt = RECV;
          w_cap       = 1'b1;
          w_first     = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bits enter at the MSB so that after N shifts bit 0 sits at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '0;
      r_cnt   <= '0;
    end else if (w_cap) begin
      r_frame <= {serial_in, r_frame[N-1:1]};
      r_cnt   <= w_first ? CW'(1) : r_cnt + CW'(1);
    end
  end

  if (HAS_ECC) begin : g_ecc
    secded_decoder #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
      .i_code          (r_frame),
      .o_data          (w_data),
      .o_corrected     (w_cor),
      .o_uncorrectable (w_unc)
    );
  end else begin : g_raw
    assign w_data = r_frame[DATA_WIDTH-1:0];
    assign w_cor  = 1'b0;
    assign w_unc  = 1'b0;
  end

  assign w_pop = r_v0 & ready_in;

  // Entry 0 is the head; it is only overwritten on a push or a shift, so it holds when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data0   <= '0;
      r_data1   <= '0;
      r_cor0    <= 1'b0;
      r_cor1    <= 1'b0;
      r_unc0    <= 1'b0;
      r_unc1    <= 1'b0;
      r_v0      <= 1'b0;
      r_v1      <= 1'b0;
      r_overrun <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_overrun <= w_push & r_v0 & r_v1 & ~w_pop;
      r_abort   <= w_abort;
      if (w_pop) begin
        if (r_v1) begin
          r_data0 <= r_data1;
          r_cor0  <= r_cor1;
          r_unc0  <= r_unc1;
        end
        r_v0 <= r_v1;
        r_v1 <= 1'b0;
        if (w_push) begin
          if (r_v1) begin
            r_data1 <= w_data;
            r_cor1  <= w_cor;
            r_unc1  <= w_unc;
            r_v1    <= 1'b1;
          end else begin
            r_data0 <= w_data;
            r_cor0  <= w_cor;
            r_unc0  <= w_unc;
            r_v0    <= 1'b1;
          end
        end
      end else if (w_push) begin
        if (!r_v0) begin
          r_data0 <= w_data;
          r_cor0  <= w_cor;
          r_unc0  <= w_unc;
          r_v0    <= 1'b1;
        end else if (!r_v1) begin
          r_data1 <= w_data;
          r_cor1  <= w_cor;
          r_unc1  <= w_unc;
          r_v1    <= 1'b1;
        end
      end
    end
  end

  assign parallel_out      = r_data0;
  assign valid_out         = r_v0;
  assign err_corrected     = r_cor0;
  assign err_uncorrectable = r_unc0;
  assign overrun           = r_overrun;
  assign frame_abort       = r_abort;

endmodule

// File: tb/tb_ecc_deserializer.sv
// Bench for ecc_deserializer: one raw (HAS_ECC=0) and one SECDED (HAS_ECC=1) instance against a frame-level model.
module tb_ecc_deserializer;

  typedef struct packed {
    logic [7:0] data;
    logic       cor;
    logic       unc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en  [2];
  logic       st  [2];
  logic       sin [2];
  logic       rdy [2];
  logic [7:0] pout[2];
  logic       vld [2];
  logic       ecor[2];
  logic       eunc[2];
  logic       ovr [2];
  logic       abt [2];

  logic rdy_rand[2];
  logic rdy_set [2];

  always #5 clk = ~clk;

  ecc_deserializer #(.DATA_WIDTH(8), .HAS_ECC(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .serial_in(sin[0]), .enable(en[0]), .start(st[0]),
    .parallel_out(pout[0]), .valid_out(vld[0]), .ready_in(rdy[0]),
    .err_corrected(ecor[0]), .err_uncorrectable(eunc[0]),
    .overrun(ovr[0]), .frame_abort(abt[0])
  );

  ecc_deserializer #(.DATA_WIDTH(8), .HAS_ECC(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .serial_in(sin[1]), .enable(en[1]), .start(st[1]),
    .parallel_out(pout[1]), .valid_out(vld[1]), .ready_in(rdy[1]),
    .err_corrected(ecor[1]), .err_uncorrectable(eunc[1]),
    .overrun(ovr[1]), .frame_abort(abt[1])
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Frame-level model: a 2-deep output queue plus a bit counter per instance.
  exp_t mq[2][2];
  int   mcnt[2];
  exp_t hold[2];
  exp_t done_w[2];
  exp_t cur_exp[2];
  bit   in_frame[2];
  bit   chk_pend[2];
  int   nbits[2];
  bit   exp_ovr[2];
  bit   exp_abt[2];

  function automatic int flen(input int d);
    return (d == 0) ? 8 : 13;
  endfunction

  task automatic model_reset(input int d);
    mcnt[d] = 0; hold[d] = '0; done_w[d] = '0; in_frame[d] = 0; chk_pend[d] = 0;
    nbits[d] = 0; exp_ovr[d] = 0; exp_abt[d] = 0;
  endtask

  task automatic check_zero(input int d);
    expect_eq($sformatf("d%0d_rst_valid", d), 32'(vld[d]), 32'd0);
    expect_eq($sformatf("d%0d_rst_data", d), 32'(pout[d]), 32'd0);
    expect_eq($sformatf("d%0d_rst_cor", d), 32'(ecor[d]), 32'd0);
    expect_eq($sformatf("d%0d_rst_unc", d), 32'(eunc[d]), 32'd0);
    expect_eq($sformatf("d%0d_rst_ovr", d), 32'(ovr[d]), 32'd0);
    expect_eq($sformatf("d%0d_rst_abt", d), 32'(abt[d]), 32'd0);
  endtask

  task automatic check_outputs(input int d);
    expect_eq($sformatf("d%0d_valid", d), 32'(vld[d]), 32'(mcnt[d] > 0));
    expect_eq($sformatf("d%0d_data", d), 32'(pout[d]), 32'(hold[d].data));
    expect_eq($sformatf("d%0d_cor", d), 32'(ecor[d]), 32'(hold[d].cor));
    expect_eq($sformatf("d%0d_unc", d), 32'(eunc[d]), 32'(hold[d].unc));
    expect_eq($sformatf("d%0d_overrun", d), 32'(ovr[d]), 32'(exp_ovr[d]));
    expect_eq($sformatf("d%0d_abort", d), 32'(abt[d]), 32'(exp_abt[d]));
  endtask

  // Advance the model across the coming rising edge using the inputs now applied.
  task automatic model_step(input int d);
    bit   push;
    exp_t pw;
    push        = chk_pend[d];
    pw          = done_w[d];
    chk_pend[d] = 0;
    exp_ovr[d]  = 0;
    exp_abt[d]  = 0;
    if (en[d] === 1'b1) begin
      if (st[d] === 1'b1) begin
        if (in_frame[d]) exp_abt[d] = 1;
        in_frame[d] = 1;
        nbits[d]    = 1;
      end else if (in_frame[d]) begin
        nbits[d]++;
        if (nbits[d] == flen(d)) begin
          in_frame[d] = 0;
          chk_pend[d] = 1;
          done_w[d]   = cur_exp[d];
        end
      end
    end
    if (mcnt[d] > 0 && rdy[d] === 1'b1) begin
      mq[d][0] = mq[d][1];
      mcnt[d]--;
    end
    if (push) begin
      if (mcnt[d] < 2) begin
        mq[d][mcnt[d]] = pw;
        mcnt[d]++;
      end else begin
        exp_ovr[d] = 1;
      end
    end
    if (mcnt[d] > 0) hold[d] = mq[d][0];
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        model_reset(d);
        check_zero(d);
      end else begin
        check_outputs(d);
        model_step(d);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++)
      rdy[d] = rdy_rand[d] ? 1'($urandom_range(0, 1)) : rdy_set[d];
  end

  // Serial bit sequence for a payload, plus the word the receiver should report.
  task automatic build(input int d, input logic [7:0] pl, input logic [15:0] flips,
                       output logic [15:0] bits, output exp_t e);
    logic [15:0] cw, cwx;
    logic [7:0]  raw;
    logic        par;
    int          di;
    bits = '0;
    e    = '0;
    if (d == 0) begin
      bits   = {8'h00, pl};
      e.data = pl;
    end else begin
      cw = '0;
      di = 0;
      for (int p = 1; p <= 12; p++)
        if ((p & (p - 1)) != 0) begin cw[p] = pl[di]; di++; end
      for (int j = 0; j < 4; j++) begin
        par = 1'b0;
        for (int p = 1; p <= 12; p++)
          if (((p >> j) & 1) == 1 && (p & (p - 1)) != 0) par = par ^ cw[p];
        cw[1 << j] = par;
      end
      cw[13] = ^cw[12:1];
      cwx    = cw ^ flips;
      for (int k = 0; k < 13; k++) bits[k] = cwx[k + 1];
      raw = '0;
      di  = 0;
      for (int p = 1; p <= 12; p++)
        if ((p & (p - 1)) != 0) begin raw[di] = cwx[p]; di++; end
      case ($countones(flips))
        0:       e.data = pl;
        1:       begin e.data = pl;  e.cor = 1'b1; end
        default: begin e.data = raw; e.unc = 1'b1; end
      endcase
    end
  endtask

  task automatic tick(input int c);
    repeat (c) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int d, input logic [7:0] pl, input logic [15:0] flips,
                      input int gap_at, input int gap_len);
    logic [15:0] bits;
    exp_t        e;
    build(d, pl, flips, bits, e);
    cur_exp[d] = e;
    for (int k = 0; k < flen(d); k++) begin
      if (k == gap_at) begin
        en[d] = 1'b0; st[d] = 1'b0;
        tick(gap_len);
      end
      en[d] = 1'b1; st[d] = (k == 0); sin[d] = bits[k];
      tick(1);
    end
    en[d] = 1'b0; st[d] = 1'b0;
  endtask

  task automatic partial(input int d, input logic [7:0] pl, input int nb);
    logic [15:0] bits;
    exp_t        e;
    build(d, pl, 16'h0, bits, e);
    for (int k = 0; k < nb; k++) begin
      en[d] = 1'b1; st[d] = (k == 0); sin[d] = bits[k];
      tick(1);
    end
    en[d] = 1'b0; st[d] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; st[d] = 1'b0; sin[d] = 1'b0; rdy[d] = 1'b1;
      rdy_rand[d] = 1'b0; rdy_set[d] = 1'b1; cur_exp[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);

    // Raw 0xA5: valid two cycles after the last bit, for one cycle.
    send(0, 8'hA5, 16'h0, -1, 0);
    expect_eq("a5_check_cycle_valid", 32'(vld[0]), 32'd0);
    tick(1);
    expect_eq("a5_valid", 32'(vld[0]), 32'd1);
    expect_eq("a5_data", 32'(pout[0]), 32'hA5);
    tick(1);
    expect_eq("a5_popped", 32'(vld[0]), 32'd0);
    tick(3);

    // SECDED: clean, single error at position 6, double error at 3 and 9.
    send(1, 8'h3C, 16'h0, -1, 0);
    send(1, 8'h3C, 16'h0040, -1, 0);
    tick(4);
    send(1, 8'h3C, 16'h0208, -1, 0);
    tick(1);
    expect_eq("dbl_data", 32'(pout[1]), 32'h2D);
    expect_eq("dbl_unc", 32'(eunc[1]), 32'd1);
    expect_eq("dbl_cor", 32'(ecor[1]), 32'd0);
    tick(3);

    // Overrun: three frames into a stalled consumer.
    rdy_set[0] = 1'b0;
    tick(2);
    send(0, 8'h11, 16'h0, -1, 0);
    send(0, 8'h22, 16'h0, -1, 0);
    send(0, 8'h33, 16'h0, -1, 0);
    tick(3);
    rdy_set[0] = 1'b1;
    tick(6);

    // Abort by early start, then a frame with an enable gap.
    partial(0, 8'h55, 4);
    send(0, 8'h99, 16'h0, -1, 0);
    tick(4);
    send(0, 8'h42, 16'h0, 3, 3);
    tick(4);

    // Asynchronous reset mid-frame with a word pending.
    rdy_set[0] = 1'b0;
    tick(2);
    send(0, 8'h11, 16'h0, -1, 0);
    tick(3);
    expect_eq("pre_rst_valid", 32'(vld[0]), 32'd1);
    partial(0, 8'h5A, 3);
    #2 rst_n = 1'b0;
    #1 check_zero(0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rdy_set[0] = 1'b1;
    tick(2);
    send(0, 8'h7E, 16'h0, -1, 0);
    tick(4);

    // Randomized traffic with random backpressure on both instances.
    rdy_rand[0] = 1'b1;
    rdy_rand[1] = 1'b1;
    for (int it = 0; it < 80; it++) begin
      int          d, nf, p1, p2, ga;
      logic [15:0] fl;
      d  = int'($urandom_range(0, 1));
      fl = '0;
      if (d == 1) begin
        nf = int'($urandom_range(0, 2));
        p1 = int'($urandom_range(1, 13));
        p2 = ((p1 - 1 + int'($urandom_range(1, 12))) % 13) + 1;
        if (nf >= 1) fl[p1] = 1'b1;
        if (nf == 2) fl[p2] = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) partial(d, 8'($urandom), int'($urandom_range(1, 6)));
      ga = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : -1;
      send(d, 8'($urandom), fl, ga, int'($urandom_range(1, 3)));
      tick(int'($urandom_range(0, 2)));
    end
    rdy_rand[0] = 1'b0;
    rdy_rand[1] = 1'b0;
    rdy_set[0]  = 1'b1;
    rdy_set[1]  = 1'b1;
    tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
